// File: rtl/upl_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one UPL transmit channel among NUM_PORTS senders.
// Define UPL_TX_ARB_TIMEOUT_EN to abandon a grant whose owner never starts sending.
module upl_tx_arbiter #(
   parameter int NUM_PORTS     = 2,
   parameter int START_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_PORTS-1:0]    req_Reqeust,
   output logic [NUM_PORTS-1:0]    req_Ack,
   input  logic [NUM_PORTS-1:0]    req_Enable,
   input  logic [32*NUM_PORTS-1:0] req_Data,
   output logic                    UPLout_Reqeust,
   input  logic                    UPLout_Ack,
   output logic                    UPLout_Enable,
   output logic [31:0]             UPLout_Data
);

   localparam int SEL_W = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_EN, ST_PASS} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [SEL_W-1:0]     r_sel;
   logic [SEL_W-1:0]     r_rr;
   logic [SEL_W-1:0]     w_winner;
   logic [SEL_W-1:0]     w_sel_inc;
   logic                 w_any;
   logic                 w_sel_en;
   logic [31:0]          w_sel_data;
   logic [31:0]          w_data_arr [NUM_PORTS];
   logic                 w_timeout;
   logic                 w_upl_req_nxt;
   logic                 w_en_nxt;
   logic                 w_data_ld;
   logic                 w_sel_ld;
   logic                 w_rr_adv;
   logic [NUM_PORTS-1:0] w_ack_nxt;
   logic                 r_upl_req;
   logic [NUM_PORTS-1:0] r_ack;
   logic                 r_en;
   logic [31:0]          r_data;

   if (NUM_PORTS < 2 || NUM_PORTS > 4) begin : g_bad_num_ports
      $error("upl_tx_arbiter: NUM_PORTS must be 2..4");
   end
   if (START_TIMEOUT < 1) begin : g_bad_timeout
      $error("upl_tx_arbiter: START_TIMEOUT must be at least 1");
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_data_split
      assign w_data_arr[g] = req_Data[32*g +: 32];
   end

   assign w_sel_en   = req_Enable[r_sel];
   assign w_sel_data = w_data_arr[r_sel];
   assign w_sel_inc  = (r_sel == SEL_W'(NUM_PORTS - 1)) ? '0 : r_sel + 1'b1;

   // First active request at or after the rr pointer, wrapping; the port just served sits last.
   always_comb begin
      logic [SEL_W-1:0] idx;
      w_any    = 1'b0;
      w_winner = r_rr;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = SEL_W'((int'(r_rr) + i) % NUM_PORTS);
         if (!w_any && req_Reqeust[idx]) begin
            w_any    = 1'b1;
            w_winner = idx;
         end
      end
   end

`ifdef UPL_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(START_TIMEOUT) > 8) ? $clog2(START_TIMEOUT) : 8;

   logic [CNT_W-1:0] r_wait_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                   r_wait_cnt <= '0;
      else if (r_state != ST_WAIT_EN) r_wait_cnt <= '0;
      else                            r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   assign w_timeout = (r_state == ST_WAIT_EN) && !w_sel_en &&
                      (r_wait_cnt == CNT_W'(START_TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_any)      w_next = ST_REQ;
         ST_REQ:     if (UPLout_Ack) w_next = ST_WAIT_EN;
         ST_WAIT_EN: begin
            if (w_sel_en)       w_next = ST_PASS;
            else if (w_timeout) w_next = ST_IDLE;
         end
         ST_PASS:    if (!w_sel_en)  w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_upl_req_nxt = 1'b0;
      w_ack_nxt     = '0;
      w_en_nxt      = 1'b0;
      w_data_ld     = 1'b0;
      w_sel_ld      = 1'b0;
      w_rr_adv      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_upl_req_nxt = w_any;
            w_sel_ld      = w_any;
         end
         ST_REQ: begin
            w_upl_req_nxt = !UPLout_Ack;
            if (UPLout_Ack) w_ack_nxt[r_sel] = 1'b1;
         end
         ST_WAIT_EN: begin
            w_en_nxt  = w_sel_en;
            w_data_ld = w_sel_en;
            w_rr_adv  = w_timeout;
         end
         ST_PASS: begin
            w_en_nxt  = w_sel_en;
            w_data_ld = w_sel_en;
            w_rr_adv  = !w_sel_en;
         end
         default: ;
      endcase
   end

   // Data keeps its last word while Enable is low so idle cycles cause no toggling.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_upl_req <= 1'b0;
         r_ack     <= '0;
         r_en      <= 1'b0;
         r_data    <= '0;
         r_sel     <= '0;
         r_rr      <= '0;
      end else begin
         r_upl_req <= w_upl_req_nxt;
         r_ack     <= w_ack_nxt;
         r_en      <= w_en_nxt;
         if (w_data_ld) r_data <= w_sel_data;
         if (w_sel_ld)  r_sel  <= w_winner;
         if (w_rr_adv)  r_rr   <= w_sel_inc;
      end
   end

   assign UPLout_Reqeust = r_upl_req;
   assign req_Ack        = r_ack;
   assign UPLout_Enable  = r_en;
   assign UPLout_Data    = r_data;

endmodule

// File: tb/tb_upl_tx_arbiter.sv
// Scoreboard bench for upl_tx_arbiter: two senders, a stack model with programmable Ack delay.
module tb_upl_tx_arbiter;

   localparam int NP = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NP-1:0] req_Reqeust;
   logic [NP-1:0] req_Ack;
   logic [NP-1:0] req_Enable;
   logic [32*NP-1:0] req_Data;
   logic          UPLout_Reqeust;
   logic          UPLout_Ack;
   logic          UPLout_Enable;
   logic [31:0]   UPLout_Data;

   logic          tbReq0, tbReq1, tbEn0, tbEn1;
   logic [31:0]   tbData0, tbData1;

   assign req_Reqeust = {tbReq1, tbReq0};
   assign req_Enable  = {tbEn1, tbEn0};
   assign req_Data    = {tbData1, tbData0};

   upl_tx_arbiter #(.NUM_PORTS(NP), .START_TIMEOUT(10)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req_Reqeust    (req_Reqeust),
      .req_Ack        (req_Ack),
      .req_Enable     (req_Enable),
      .req_Data       (req_Data),
      .UPLout_Reqeust (UPLout_Reqeust),
      .UPLout_Ack     (UPLout_Ack),
      .UPLout_Enable  (UPLout_Enable),
      .UPLout_Data    (UPLout_Data)
   );

   always #5 clk = ~clk;

   int          nCompared = 0;
   int          nMismatched = 0;
   int          cycleCount = 0;
   int          stackDelay = 2;
   logic [31:0] expQ[$];
   int          ackOrder[$];
   int          ackCycles[$];
   int          runLens[$];
   int          runStarts[$];
   int          runEnds[$];
   int          curRun = 0;
   int          ackCount[NP];
   int          firstDrive[NP];
   logic [NP-1:0] prevAck = '0;
   logic [31:0] monExp;
   logic [31:0] pktMem[NP][16];
   int          pktLen[NP];

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Output monitor: pops the scoreboard for every word and records grant/run history.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (UPLout_Enable) begin
            if (curRun == 0) runStarts.push_back(cycleCount);
            curRun++;
            nCompared++;
            if (expQ.size() == 0) begin
               nMismatched++;
               $display("[TB] FAIL word_extra: got %h, expected no word", UPLout_Data);
            end else begin
               monExp = expQ.pop_front();
               if (UPLout_Data !== monExp) begin
                  nMismatched++;
                  $display("[TB] FAIL word_data: got %h, expected %h", UPLout_Data, monExp);
               end
            end
         end else if (curRun > 0) begin
            runLens.push_back(curRun);
            runEnds.push_back(cycleCount);
            curRun = 0;
         end
         if (req_Ack != '0) begin
            nCompared++;
            if (req_Ack == 2'b11 || UPLout_Enable || prevAck != '0) begin
               nMismatched++;
               $display("[TB] FAIL ack_shape: got ack=%b en=%b prevAck=%b, expected one-hot single-cycle ack outside data",
                        req_Ack, UPLout_Enable, prevAck);
            end
            for (int i = 0; i < NP; i++) begin
               if (req_Ack[i]) begin
                  ackCount[i]++;
                  ackOrder.push_back(i);
                  ackCycles.push_back(cycleCount);
               end
            end
         end
         prevAck = req_Ack;
      end else begin
         curRun  = 0;
         prevAck = '0;
      end
   end

   // Stack model: answers each UPLout_Reqeust with a one-cycle Ack after stackDelay cycles.
   initial begin
      UPLout_Ack = 1'b0;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && UPLout_Reqeust === 1'b1) begin
            repeat (stackDelay) @(negedge clk);
            UPLout_Ack = 1'b1;
            @(negedge clk);
            UPLout_Ack = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic setReq(input int p, input logic v);
      if (p == 0) tbReq0 = v;
      else        tbReq1 = v;
   endtask

   task automatic setEn(input int p, input logic en, input logic [31:0] d);
      if (p == 0) begin tbEn0 = en; tbData0 = d; end
      else        begin tbEn1 = en; tbData1 = d; end
   endtask

   task automatic fillPkt(input int p, input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) pktMem[1'(p)][4'(k)] = base + 32'(k);
      pktLen[1'(p)] = n;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      tbReq0 = 0; tbReq1 = 0; tbEn0 = 0; tbEn1 = 0; tbData0 = '0; tbData1 = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      expQ.delete();
      @(negedge clk);
   endtask

   // Requests, waits for the grant, then streams the prepared words back to back.
   task automatic sendPacket(input int p);
      bit got = 0;
      setReq(p, 1'b1);
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         if (req_Ack[1'(p)]) got = 1;
      end
      setReq(p, 1'b0);
      if (!got) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL ack_timeout: port %0d got no req_Ack, expected one within 100 cycles", p);
      end else begin
         firstDrive[1'(p)] = cycleCount;
         for (int k = 0; k < pktLen[1'(p)]; k++) begin
            setEn(p, 1'b1, pktMem[1'(p)][4'(k)]);
            expQ.push_back(pktMem[1'(p)][4'(k)]);
            @(negedge clk);
         end
         setEn(p, 1'b0, 32'hDEAD_0000);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tbReq0 = 0; tbReq1 = 0; tbEn0 = 0; tbEn1 = 0; tbData0 = '0; tbData1 = '0;
      #3;
      nCompared++;
      if ({UPLout_Reqeust, UPLout_Enable, UPLout_Data, req_Ack} !== '0) begin
         nMismatched++;
         $display("[TB] FAIL reset_outputs: got req=%b en=%b data=%h ack=%b, expected all 0",
                  UPLout_Reqeust, UPLout_Enable, UPLout_Data, req_Ack);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      nCompared++;
      if ({UPLout_Reqeust, UPLout_Enable, UPLout_Data, req_Ack} !== '0) begin
         nMismatched++;
         $display("[TB] FAIL idle_outputs: got req=%b en=%b data=%h ack=%b, expected all 0",
                  UPLout_Reqeust, UPLout_Enable, UPLout_Data, req_Ack);
      end
   endtask

   task automatic test_single_packet();
      int a0 = ackCount[0];
      int a1 = ackCount[1];
      stackDelay = 2;
      pktMem[0][0] = 32'hC0A8_000A; pktMem[0][1] = 32'hC0A8_0001;
      pktMem[0][2] = 32'h4000_4001; pktMem[0][3] = 32'h0000_0008;
      pktMem[0][4] = 32'h5375_6d3a; pktMem[0][5] = 32'h0000_0007;
      pktLen[0] = 6;
      sendPacket(0);
      repeat (3) @(negedge clk);
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL single_drain: got %0d words pending, expected 0", expQ.size());
      end
      nCompared++;
      if (ackCount[0] - a0 != 1 || ackCount[1] != a1) begin
         nMismatched++;
         $display("[TB] FAIL single_acks: got ack0 +%0d ack1 +%0d, expected +1 and +0",
                  ackCount[0] - a0, ackCount[1] - a1);
      end
      nCompared++;
      if (runLens.size() == 0 || runLens[runLens.size()-1] != 6) begin
         nMismatched++;
         $display("[TB] FAIL single_contiguous: got run length %0d, expected 6",
                  (runLens.size() == 0) ? -1 : runLens[runLens.size()-1]);
      end
      nCompared++;
      if (runStarts.size() == 0 || runStarts[runStarts.size()-1] - firstDrive[0] != 1) begin
         nMismatched++;
         $display("[TB] FAIL single_latency: got %0d cycles, expected 1",
                  (runStarts.size() == 0) ? -1 : runStarts[runStarts.size()-1] - firstDrive[0]);
      end
   endtask

   task automatic test_simultaneous();
      int base;
      doReset();
      stackDelay = 1;
      // From reset rr=0: port 0 then port 1 (rr returns to 0).
      fillPkt(0, 3, 32'hA000_0000);
      fillPkt(1, 4, 32'hB000_0000);
      base = ackOrder.size();
      fork
         sendPacket(0);
         sendPacket(1);
      join
      repeat (3) @(negedge clk);
      nCompared++;
      if (ackOrder.size() != base + 2 || ackOrder[base] != 0 || ackOrder[base+1] != 1) begin
         nMismatched++;
         $display("[TB] FAIL pair_order_first: got %0d grants starting %0d, expected 2 grants 0,1",
                  ackOrder.size() - base, ackOrder[base]);
      end
      // A lone port-0 packet moves rr to 1, so the next pair is served 1 then 0.
      fillPkt(0, 2, 32'hA100_0000);
      sendPacket(0);
      repeat (2) @(negedge clk);
      fillPkt(0, 3, 32'hA200_0000);
      fillPkt(1, 3, 32'hB200_0000);
      base = ackOrder.size();
      fork
         sendPacket(0);
         sendPacket(1);
      join
      repeat (3) @(negedge clk);
      nCompared++;
      if (ackOrder.size() != base + 2 || ackOrder[base] != 1 || ackOrder[base+1] != 0) begin
         nMismatched++;
         $display("[TB] FAIL pair_order_second: got %0d grants starting %0d, expected 2 grants 1,0",
                  ackOrder.size() - base, ackOrder[base]);
      end
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL pair_drain: got %0d words pending, expected 0", expQ.size());
      end
   endtask

   task automatic test_pass_block();
      int base = ackOrder.size();
      int a0   = ackCount[0];
      stackDelay = 0;
      fillPkt(0, 8, 32'hC000_0000);
      fillPkt(1, 3, 32'hD000_0000);
      fork
         sendPacket(0);
         begin
            for (int c = 0; c < 100 && ackCount[0] == a0; c++) @(negedge clk);
            repeat (3) @(negedge clk);
            sendPacket(1);
         end
      join
      repeat (3) @(negedge clk);
      nCompared++;
      if (ackOrder.size() != base + 2 || ackOrder[base] != 0 || ackOrder[base+1] != 1) begin
         nMismatched++;
         $display("[TB] FAIL pass_order: got %0d grants starting %0d, expected 0 then 1",
                  ackOrder.size() - base, ackOrder[base]);
      end
      nCompared++;
      if (runEnds.size() < 2 || ackCycles[ackCycles.size()-1] <= runEnds[runEnds.size()-2]) begin
         nMismatched++;
         $display("[TB] FAIL pass_block: got port1 ack at cycle %0d, expected after port0 end at %0d",
                  ackCycles[ackCycles.size()-1], (runEnds.size() < 2) ? -1 : runEnds[runEnds.size()-2]);
      end
   endtask

   task automatic test_random_delay();
      int a0 = ackCount[0];
      int a1 = ackCount[1];
      int expLen[4];
      bit done = 0;
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               stackDelay = $urandom_range(0, 20);
               expLen[k]  = $urandom_range(3, 6);
               fillPkt(0, expLen[k], 32'hE000_0000 + 32'(k << 8));
               sendPacket(0);
               repeat (2) @(negedge clk);
            end
            done = 1;
         end
         while (!done) begin
            @(negedge clk);
            tbEn1   = 1'($urandom);
            tbData1 = $urandom;
         end
      join
      tbEn1 = 1'b0;
      repeat (2) @(negedge clk);
      nCompared++;
      if (ackCount[1] != a1 || ackCount[0] - a0 != 4) begin
         nMismatched++;
         $display("[TB] FAIL junk_acks: got ack0 +%0d ack1 +%0d, expected +4 and +0",
                  ackCount[0] - a0, ackCount[1] - a1);
      end
      for (int k = 0; k < 4; k++) begin
         int idx = runLens.size() - 4 + k;
         nCompared++;
         if (idx < 0 || runLens[idx] != expLen[k]) begin
            nMismatched++;
            $display("[TB] FAIL junk_len%0d: got %0d, expected %0d", k,
                     (idx < 0) ? -1 : runLens[idx], expLen[k]);
         end
      end
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL junk_drain: got %0d words pending, expected 0", expQ.size());
      end
   endtask

   task automatic test_reset_midpacket();
      bit got = 0;
      int base;
      stackDelay = 1;
      setReq(0, 1'b1);
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         if (req_Ack[0]) got = 1;
      end
      setReq(0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         setEn(0, 1'b1, 32'hF000_0000 + 32'(k));
         if (k < 2) expQ.push_back(32'hF000_0000 + 32'(k));
         if (k < 2) @(negedge clk);
      end
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      nCompared++;
      if (!got || {UPLout_Reqeust, UPLout_Enable, UPLout_Data, req_Ack} !== '0) begin
         nMismatched++;
         $display("[TB] FAIL async_reset: got granted=%0d req=%b en=%b data=%h ack=%b, expected grant and all 0",
                  got, UPLout_Reqeust, UPLout_Enable, UPLout_Data, req_Ack);
      end
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL trunc_words: got %0d of first two words missing, expected 0", expQ.size());
      end
      setEn(0, 1'b0, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      base = ackOrder.size();
      fillPkt(1, 4, 32'h1100_0000);
      sendPacket(1);
      repeat (3) @(negedge clk);
      nCompared++;
      if (ackOrder.size() != base + 1 || ackOrder[base] != 1 || expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL post_reset_grant: got %0d grants first %0d pending %0d, expected 1 grant to 1, 0 pending",
                  ackOrder.size() - base, ackOrder[base], expQ.size());
      end
   endtask

   task automatic test_no_enable();
      int a0;
      int a1;
      doReset();
      stackDelay = 0;
      a0 = ackCount[0];
      a1 = ackCount[1];
      setReq(0, 1'b1);
      for (int c = 0; c < 100 && ackCount[0] == a0; c++) @(negedge clk);
      setReq(0, 1'b0);
`ifdef UPL_TX_ARB_TIMEOUT_EN
      fillPkt(1, 2, 32'h2200_0000);
      sendPacket(1);
      repeat (3) @(negedge clk);
      nCompared++;
      if (ackCount[1] - a1 != 1 || ackCycles[ackCycles.size()-1] - ackCycles[ackCycles.size()-2] != 12) begin
         nMismatched++;
         $display("[TB] FAIL timeout_regrant: got ack1 +%0d gap %0d, expected +1 gap 12",
                  ackCount[1] - a1, ackCycles[ackCycles.size()-1] - ackCycles[ackCycles.size()-2]);
      end
`else
      setReq(1, 1'b1);
      repeat (40) @(negedge clk);
      nCompared++;
      if (ackCount[0] - a0 != 1 || ackCount[1] != a1 || UPLout_Reqeust !== 1'b0 || UPLout_Enable !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL wait_forever: got ack0 +%0d ack1 +%0d req=%b en=%b, expected +1 +0 0 0",
                  ackCount[0] - a0, ackCount[1] - a1, UPLout_Reqeust, UPLout_Enable);
      end
      setReq(1, 1'b0);
      doReset();
`endif
   endtask

   initial begin
      for (int i = 0; i < NP; i++) begin
         ackCount[i]   = 0;
         firstDrive[i] = 0;
      end
      test_reset();
      test_single_packet();
      test_simultaneous();
      test_pass_block();
      test_random_delay();
      test_reset_midpacket();
      test_no_enable();
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
